// File: rtl/dds_ctrl_pkg.sv
// Shared types and constants for the DDS sweep controller.
// Holds the sweep state encoding, mode codes and default widths.
package dds_ctrl_pkg;

    localparam int FW_W_DEF    = 32;
    localparam int PW_W_DEF    = 12;
    localparam int DWELL_W_DEF = 16;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell down-counter: strobes o_expire combinationally in the cycle the count is 0 while enabled.
// Reloads on i_load or on expiry; no backpressure.
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int W = DWELL_W_DEF
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_load_val,
    input  logic         i_load,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    assign o_expire = i_en && !i_load && (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load || o_expire) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving dds_gen Fword/Pword (single, sawtooth, triangle).
// Outputs are registered, one cycle after the triggering input; no backpressure.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FW_W    = FW_W_DEF,
    parameter int PW_W    = PW_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
)(
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Cfg_Load,
    input  logic [FW_W-1:0]    Cfg_Fstart,
    input  logic [FW_W-1:0]    Cfg_Fstop,
    input  logic [FW_W-1:0]    Cfg_Fstep,
    input  logic [DWELL_W-1:0] Cfg_Dwell,
    input  logic [1:0]         Cfg_Mode,
    input  logic [PW_W-1:0]    Cfg_Pword,
    input  logic               Start,
    input  logic               Abort,
    output logic [FW_W-1:0]    Fword,
    output logic [PW_W-1:0]    Pword,
    output logic               Busy,
    output logic               Hop,
    output logic               Done,
    output logic               Cfg_Err
);

    // Widened add so a step near the top of the range clamps instead of wrapping.
    function automatic logic [FW_W-1:0] f_up_next(input logic [FW_W-1:0] cur,
                                                  input logic [FW_W-1:0] step,
                                                  input logic [FW_W-1:0] lim);
        logic [FW_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum > {1'b0, lim}) ? lim : sum[FW_W-1:0];
    endfunction

    function automatic logic [FW_W-1:0] f_down_next(input logic [FW_W-1:0] cur,
                                                    input logic [FW_W-1:0] step,
                                                    input logic [FW_W-1:0] lim);
        return ((cur - lim) < step) ? lim : (cur - step);
    endfunction

    sweep_state_t       r_state;
    logic [FW_W-1:0]    r_fword;
    logic [FW_W-1:0]    r_fstart;
    logic [FW_W-1:0]    r_fstop;
    logic [FW_W-1:0]    r_fstep;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_mode;
    logic [PW_W-1:0]    r_pword;
    logic               r_hop;
    logic               r_done;
    logic               r_err;

    sweep_state_t       w_state_nxt;
    logic [FW_W-1:0]    w_fword_nxt;
    logic               w_hop_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_tmr_load;
    logic               w_tmr_exp;
    logic               w_busy;
    logic               w_load_ok;
    logic [FW_W-1:0]    w_fstart;
    logic [FW_W-1:0]    w_fstop;
    logic [FW_W-1:0]    w_fstep;
    logic [DWELL_W-1:0] w_dwell;
    logic               w_cfg_valid;
    logic [FW_W-1:0]    w_up_nxt;
    logic [FW_W-1:0]    w_dn_nxt;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_load_ok = Cfg_Load && !w_busy;

    // A load coinciding with Start must be judged against the incoming values.
    assign w_fstart    = w_load_ok ? Cfg_Fstart : r_fstart;
    assign w_fstop     = w_load_ok ? Cfg_Fstop  : r_fstop;
    assign w_fstep     = w_load_ok ? Cfg_Fstep  : r_fstep;
    assign w_dwell     = w_load_ok ? Cfg_Dwell  : r_dwell;
    assign w_cfg_valid = (w_fstep != '0) && (w_fstart <= w_fstop);

    assign w_up_nxt = f_up_next(r_fword, r_fstep, r_fstop);
    assign w_dn_nxt = f_down_next(r_fword, r_fstep, r_fstart);

    dds_dwell_timer #(.W(DWELL_W)) u_dwell (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_load_val (w_dwell),
        .i_load     (w_tmr_load),
        .i_en       (w_busy),
        .o_expire   (w_tmr_exp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_fword_nxt = r_fword;
        w_hop_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_tmr_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    if (w_cfg_valid) begin
                        w_state_nxt = ST_UP;
                        w_fword_nxt = w_fstart;
                        w_hop_nxt   = 1'b1;
                        w_tmr_load  = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_err_nxt = Cfg_Load;
                if (Abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_exp) begin
                    if (r_state == ST_UP) begin
                        if (r_fword != r_fstop) begin
                            w_fword_nxt = w_up_nxt;
                            w_hop_nxt   = 1'b1;
                        end else begin
                            case (r_mode)
                                MODE_SAW: begin
                                    w_fword_nxt = r_fstart;
                                    w_hop_nxt   = 1'b1;
                                end
                                MODE_TRI: begin
                                    w_state_nxt = ST_DOWN;
                                    w_fword_nxt = w_dn_nxt;
                                    w_hop_nxt   = (w_dn_nxt != r_fword);
                                end
                                MODE_SINGLE, MODE_RSVD: begin
                                    w_state_nxt = ST_IDLE;
                                    w_done_nxt  = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        // Reaching the floor turns around and takes the up step in the same cycle.
                        if (r_fword != r_fstart) begin
                            w_fword_nxt = w_dn_nxt;
                            w_hop_nxt   = (w_dn_nxt != r_fword);
                        end else begin
                            w_state_nxt = ST_UP;
                            w_fword_nxt = w_up_nxt;
                            w_hop_nxt   = (w_up_nxt != r_fword);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_fword  <= '0;
            r_fstart <= '0;
            r_fstop  <= '0;
            r_fstep  <= '0;
            r_dwell  <= '0;
            r_mode   <= '0;
            r_pword  <= '0;
            r_hop    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fword <= w_fword_nxt;
            r_hop   <= w_hop_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_load_ok) begin
                r_fstart <= Cfg_Fstart;
                r_fstop  <= Cfg_Fstop;
                r_fstep  <= Cfg_Fstep;
                r_dwell  <= Cfg_Dwell;
                r_mode   <= Cfg_Mode;
                r_pword  <= Cfg_Pword;
            end
        end
    end

    assign Fword   = r_fword;
    assign Pword   = r_pword;
    assign Busy    = w_busy;
    assign Hop     = r_hop;
    assign Done    = r_done;
    assign Cfg_Err = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: each task drives one scenario and checks against hand-derived values.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_dds_sweep_ctrl;
    import dds_ctrl_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        Cfg_Load;
    logic [31:0] Cfg_Fstart;
    logic [31:0] Cfg_Fstop;
    logic [31:0] Cfg_Fstep;
    logic [15:0] Cfg_Dwell;
    logic [1:0]  Cfg_Mode;
    logic [11:0] Cfg_Pword;
    logic        Start;
    logic        Abort;
    logic [31:0] Fword;
    logic [11:0] Pword;
    logic        Busy;
    logic        Hop;
    logic        Done;
    logic        Cfg_Err;

    int checks = 0;
    int errors = 0;

    dds_sweep_ctrl #(.FW_W(32), .PW_W(12), .DWELL_W(16)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Cfg_Load   (Cfg_Load),
        .Cfg_Fstart (Cfg_Fstart),
        .Cfg_Fstop  (Cfg_Fstop),
        .Cfg_Fstep  (Cfg_Fstep),
        .Cfg_Dwell  (Cfg_Dwell),
        .Cfg_Mode   (Cfg_Mode),
        .Cfg_Pword  (Cfg_Pword),
        .Start      (Start),
        .Abort      (Abort),
        .Fword      (Fword),
        .Pword      (Pword),
        .Busy       (Busy),
        .Hop        (Hop),
        .Done       (Done),
        .Cfg_Err    (Cfg_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                           input logic [15:0] dw, input logic [1:0] md, input logic [11:0] pw);
        Cfg_Fstart = fs;
        Cfg_Fstop  = fe;
        Cfg_Fstep  = st;
        Cfg_Dwell  = dw;
        Cfg_Mode   = md;
        Cfg_Pword  = pw;
    endtask

    task automatic load_then_start();
        Cfg_Load = 1'b1;
        tick();
        Cfg_Load = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        Cfg_Load = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        set_cfg(32'd0, 32'd0, 32'd0, 16'd0, MODE_SINGLE, 12'd0);
        #12;
        checks++;
        if (Fword !== 32'd0) begin errors++; $display("FAIL reset_fword got=%0h exp=0", Fword); end
        checks++;
        if (Pword !== 12'd0) begin errors++; $display("FAIL reset_pword got=%0h exp=0", Pword); end
        checks++;
        if ({Busy, Hop, Done, Cfg_Err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {Busy, Hop, Done, Cfg_Err});
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({Busy, Fword} !== {1'b0, 32'd0}) begin
            errors++; $display("FAIL reset_idle busy=%b fword=%0h exp busy=0 fword=0", Busy, Fword);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_fw;
        logic        exp_busy;
        logic        exp_hop;
        logic        exp_done;
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, 12'd0);
        Cfg_Load = 1'b1;
        tick();
        Cfg_Load = 1'b0;
        checks++;
        if (Fword !== 32'd0) begin errors++; $display("FAIL single_load_fword got=%0h exp=0", Fword); end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 12) begin
                exp_fw   = 32'd100 + 32'd10 * 32'((c - 1) / 3);
                exp_busy = 1'b1;
                exp_hop  = ((c - 1) % 3) == 0;
                exp_done = 1'b0;
            end else begin
                exp_fw   = 32'd130;
                exp_busy = 1'b0;
                exp_hop  = 1'b0;
                exp_done = (c == 13);
            end
            checks++;
            if ({Fword, Busy, Hop, Done} !== {exp_fw, exp_busy, exp_hop, exp_done}) begin
                errors++;
                $display("FAIL single_seq c=%0d got fw=%0d busy=%b hop=%b done=%b exp fw=%0d busy=%b hop=%b done=%b",
                         c, Fword, Busy, Hop, Done, exp_fw, exp_busy, exp_hop, exp_done);
            end
            tick();
        end
    endtask

    task automatic test_triangle();
        logic [31:0] seq [12];
        seq = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd15, 32'd5, 32'd0, 32'd10, 32'd20, 32'd25, 32'd15, 32'd5};
        set_cfg(32'd0, 32'd25, 32'd10, 16'd0, MODE_TRI, 12'd0);
        load_then_start();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({Fword, Hop, Busy} !== {seq[i], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL tri_seq i=%0d got fw=%0d hop=%b busy=%b exp fw=%0d hop=1 busy=1", i, Fword, Hop, Busy, seq[i]);
            end
            if (i < 11) tick();
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checks++;
        if ({Busy, Hop, Done, Fword} !== {3'b000, 32'd5}) begin
            errors++; $display("FAIL tri_abort got busy=%b hop=%b done=%b fw=%0d exp 0 0 0 5", Busy, Hop, Done, Fword);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_fw;
        set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, MODE_SAW, 12'd0);
        load_then_start();
        for (int i = 0; i < 6; i++) begin
            exp_fw = (i % 2 == 0) ? 32'hFFFF_FFF0 : 32'hFFFF_FFFF;
            checks++;
            if ({Fword, Hop} !== {exp_fw, 1'b1}) begin
                errors++; $display("FAIL ovf_seq i=%0d got fw=%h hop=%b exp fw=%h hop=1", i, Fword, Hop, exp_fw);
            end
            tick();
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checks++;
        if ({Busy, Fword} !== {1'b0, 32'hFFFF_FFF0}) begin
            errors++; $display("FAIL ovf_abort got busy=%b fw=%h exp busy=0 fw=fffffff0", Busy, Fword);
        end
    endtask

    task automatic test_errors();
        // Zero step is rejected.
        set_cfg(32'd0, 32'd10, 32'd0, 16'd0, MODE_SINGLE, 12'd0);
        load_then_start();
        checks++;
        if ({Cfg_Err, Busy} !== 2'b10) begin
            errors++; $display("FAIL err_step0 got err=%b busy=%b exp err=1 busy=0", Cfg_Err, Busy);
        end
        tick();
        checks++;
        if ({Cfg_Err, Busy} !== 2'b00) begin
            errors++; $display("FAIL err_step0_after got err=%b busy=%b exp 0 0", Cfg_Err, Busy);
        end
        // Load+Start together with Fstart > Fstop: judged against the new values.
        set_cfg(32'd50, 32'd40, 32'd5, 16'd0, MODE_SINGLE, 12'd0);
        Cfg_Load = 1'b1;
        Start = 1'b1;
        tick();
        Cfg_Load = 1'b0;
        Start = 1'b0;
        checks++;
        if ({Cfg_Err, Busy} !== 2'b10) begin
            errors++; $display("FAIL err_order got err=%b busy=%b exp err=1 busy=0", Cfg_Err, Busy);
        end
        // Load+Start together with a valid config starts immediately.
        set_cfg(32'd200, 32'd300, 32'd50, 16'd0, MODE_SINGLE, 12'd0);
        Cfg_Load = 1'b1;
        Start = 1'b1;
        tick();
        Cfg_Load = 1'b0;
        Start = 1'b0;
        checks++;
        if ({Busy, Hop, Cfg_Err, Fword} !== {3'b110, 32'd200}) begin
            errors++; $display("FAIL load_start got busy=%b hop=%b err=%b fw=%0d exp 1 1 0 200", Busy, Hop, Cfg_Err, Fword);
        end
        tick();
        tick();
        tick();
        checks++;
        if ({Done, Busy, Fword} !== {2'b10, 32'd300}) begin
            errors++; $display("FAIL load_start_done got done=%b busy=%b fw=%0d exp 1 0 300", Done, Busy, Fword);
        end
        // Load while busy is rejected and the sweep keeps its old config.
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SAW, 12'h0AA);
        load_then_start();
        set_cfg(32'd500, 32'd900, 32'd50, 16'd0, MODE_TRI, 12'h0BB);
        Cfg_Load = 1'b1;
        tick();
        Cfg_Load = 1'b0;
        checks++;
        if ({Cfg_Err, Busy, Pword, Fword} !== {2'b11, 12'h0AA, 32'd100}) begin
            errors++;
            $display("FAIL err_busy_load got err=%b busy=%b pw=%h fw=%0d exp 1 1 0aa 100", Cfg_Err, Busy, Pword, Fword);
        end
        tick();
        checks++;
        if (Cfg_Err !== 1'b0) begin errors++; $display("FAIL err_busy_pulse got=%b exp=0", Cfg_Err); end
        for (int c = 3; c < 13; c++) tick();
        checks++;
        if ({Fword, Hop, Busy} !== {32'd100, 2'b11}) begin
            errors++; $display("FAIL err_busy_wrap got fw=%0d hop=%b busy=%b exp 100 1 1", Fword, Hop, Busy);
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        // Start and Abort together in IDLE: Abort wins.
        Start = 1'b1;
        Abort = 1'b1;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        checks++;
        if ({Busy, Hop, Cfg_Err} !== 3'b000) begin
            errors++; $display("FAIL start_abort got busy=%b hop=%b err=%b exp 000", Busy, Hop, Cfg_Err);
        end
    endtask

    task automatic test_abort();
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, 12'd0);
        load_then_start();
        tick();
        tick();
        tick();
        checks++;
        if ({Fword, Hop} !== {32'd110, 1'b1}) begin
            errors++; $display("FAIL abort_pre got fw=%0d hop=%b exp 110 1", Fword, Hop);
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        checks++;
        if ({Busy, Hop, Done, Fword} !== {3'b000, 32'd110}) begin
            errors++; $display("FAIL abort_post got busy=%b hop=%b done=%b fw=%0d exp 0 0 0 110", Busy, Hop, Done, Fword);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({Done, Busy, Fword} !== {2'b00, 32'd110}) begin
                errors++; $display("FAIL abort_hold c=%0d got done=%b busy=%b fw=%0d exp 0 0 110", c, Done, Busy, Fword);
            end
        end
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, 12'h123);
        Cfg_Load = 1'b1;
        checks++;
        if (Pword !== 12'h000) begin errors++; $display("FAIL pword_pre got=%h exp=000", Pword); end
        tick();
        Cfg_Load = 1'b0;
        checks++;
        if ({Pword, Fword} !== {12'h123, 32'd110}) begin
            errors++; $display("FAIL pword_load got pw=%h fw=%0d exp 123 110", Pword, Fword);
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(32'd100, 32'd130, 32'd10, 16'd2, MODE_SINGLE, 12'h055);
        load_then_start();
        tick();
        tick();
        checks++;
        if ({Busy, Fword} !== {1'b1, 32'd100}) begin
            errors++; $display("FAIL rstmid_pre got busy=%b fw=%0d exp 1 100", Busy, Fword);
        end
        Rst_n = 1'b0;
        #2;
        checks++;
        if ({Fword, Pword, Busy, Hop, Done, Cfg_Err} !== {32'd0, 12'd0, 4'b0000}) begin
            errors++;
            $display("FAIL rstmid_async got fw=%0d pw=%h flags=%b exp 0 0 0000", Fword, Pword, {Busy, Hop, Done, Cfg_Err});
        end
        tick();
        Rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({Busy, Fword, Pword} !== {1'b0, 32'd0, 12'd0}) begin
            errors++; $display("FAIL rstmid_release got busy=%b fw=%0d pw=%h exp 0 0 0", Busy, Fword, Pword);
        end
        // Shadows were cleared, so a bare Start sees Fstep = 0 and is rejected.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if ({Cfg_Err, Busy} !== 2'b10) begin
            errors++; $display("FAIL rstmid_shadow got err=%b busy=%b exp 1 0", Cfg_Err, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_triangle();
        test_overflow();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the Fword/Pword inputs of the dds_gen phase-accumulator DDS.
- Produces linear frequency sweeps between programmable start and stop tuning words, holding each step for a programmable dwell time.
- Supports single-shot, sawtooth-repeat and triangle modes, with start, abort and a config-load handshake.
- Sits between the control/register interface and dds_gen, in the same Clk domain.

Parameters:
- FW_W, 32, frequency tuning word width; must match the dds_gen Fword width.
- PW_W, 12, phase word width; must match the dds_gen Pword width.
- DWELL_W, 16, dwell counter width.

Ports:
- Clk  in  1  system clock; same clock as dds_gen.
- Rst_n  in  1  asynchronous active-low reset.
- Cfg_Load  in  1  single-cycle pulse; captures all Cfg_* inputs into shadow registers.
- Cfg_Fstart  in  FW_W  sweep start tuning word.
- Cfg_Fstop  in  FW_W  sweep stop tuning word.
- Cfg_Fstep  in  FW_W  tuning-word increment per step.
- Cfg_Dwell  in  DWELL_W  each step is held for Cfg_Dwell+1 clocks.
- Cfg_Mode  in  2  0 = single, 1 = sawtooth repeat, 2 = triangle, 3 = reserved (behaves as single).
- Cfg_Pword  in  PW_W  phase offset passed through to the DDS.
- Start  in  1  pulse; begins a sweep.
- Abort  in  1  pulse; stops the sweep.
- Fword  out  FW_W  tuning word to dds_gen.
- Pword  out  PW_W  phase word to dds_gen.
- Busy  out  1  high while a sweep is running.
- Hop  out  1  one-cycle pulse in the cycle Fword takes a new value during a sweep.
- Done  out  1  one-cycle pulse when a single-mode sweep completes.
- Cfg_Err  out  1  one-cycle pulse on a rejected load or rejected start.

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Rst_n). Every register is cleared on reset.
- Reset values: Fword = 0, Pword = 0, Busy = 0, Hop = 0, Done = 0, Cfg_Err = 0, all shadow registers = 0, state = IDLE.
- States: IDLE, UP, DOWN.
- Cfg_Load in IDLE:
  - Shadows are captured at the clock edge.
  - Pword updates on the next cycle.
  - Fword does not change.
- Cfg_Load while Busy: ignored, shadows unchanged, Cfg_Err pulses on the next cycle.
- Start in IDLE:
  - Config is valid when Fstep != 0 and Fstart <= Fstop (unsigned).
  - If valid: on the next cycle Fword = Fstart, Busy = 1, Hop = 1, dwell counter loaded with Dwell, state = UP.
  - If invalid: Cfg_Err pulses and the block stays in IDLE.
- Start while Busy: ignored, no error.
- Dwell counter: decrements each cycle while Busy. When the counter is 0, the next cycle performs a step and reloads the counter with Dwell.
- UP step:
  - Compute the sum with a (FW_W+1)-bit add: next = min(Fword + Fstep, Fstop). This removes overflow.
  - If Fword already equals Fstop, the leg has ended:
    - single/reserved: IDLE, Busy = 0, Done = 1 for one cycle, Fword holds Fstop.
    - sawtooth: Fword = Fstart, Hop = 1, remain in UP.
    - triangle: go to DOWN and perform the DOWN step in the same cycle. If Fstart == Fstop, Fword is unchanged and Hop = 0.
  - Otherwise Fword = next, Hop = 1.
- DOWN step:
  - next = max(Fword - Fstep, Fstart), with underflow guarded (if Fword - Fstart < Fstep, next = Fstart).
  - If Fword already equals Fstart, go to UP and perform the UP step in the same cycle.
  - Hop pulses whenever Fword changes value.
- Dwell = 0: a step occurs every cycle.
- Fstart == Fstop, single mode: Fword = Fstart for Dwell+1 cycles, then Done.
- Abort: from UP or DOWN, return to IDLE on the next cycle.
  - Busy = 0, Fword holds its last value, no Done, no Hop.
  - Abort in IDLE has no effect.
- Abort and Start in the same cycle: Abort wins; no sweep starts.
- Cfg_Load and Start in the same cycle while IDLE: the load is captured and Start is evaluated against the newly loaded values.
- Reset asserted mid-sweep: immediately returns all outputs to their reset values.

Decomposition:
- Package dds_ctrl_pkg holds:
  - the state enum (IDLE/UP/DOWN);
  - mode constants MODE_SINGLE = 0, MODE_SAW = 1, MODE_TRI = 2;
  - default widths.
- One natural sub-module: dds_dwell_timer.
  - Inputs: load value, load, enable.
  - Output: a one-cycle expiry strobe.
  - Instanced once.

Test Plan:
- Reset mid-sweep: drive Rst_n = 0 during UP -> all outputs 0 asynchronously; Busy stays 0 after release until a new Start.
- Single-mode sweep: load Fstart = 100, Fstop = 130, Fstep = 10, Dwell = 2, mode 0, Start -> Fword runs 100, 110, 120, 130, each value for 3 cycles, with a Hop on every change. Done pulses once 3 cycles after 130 first appears, then Busy = 0 and Fword holds 130.
- Clamping and triangle: Fstart = 0, Fstop = 25, Fstep = 10, Dwell = 0, mode 2 -> Fword runs 0, 10, 20, 25, 15, 5, 0, 10 … with no overflow or underflow.
- Overflow guard: Fstart = 0xFFFFFFF0, Fstop = 0xFFFFFFFF, Fstep = 0x20, mode 1 -> Fword runs 0xFFFFFFF0, 0xFFFFFFFF, 0xFFFFFFF0 … and never wraps to a small value.
- Error paths, part 1: Start with Fstep = 0 -> Cfg_Err pulse, Busy stays 0.
- Error paths, part 2: Cfg_Load while Busy -> Cfg_Err pulse and the sweep continues with the old values.
- Error paths, part 3: Start and Abort together in IDLE -> no Busy.
- Abort mid-sweep: Abort when Fword = 110 -> Busy = 0 on the next cycle, Fword stays 110, Done never asserted. Then Pword = 0x123 loaded -> Pword = 0x123 one cycle after Cfg_Load.
